// File: rtl/cpu_program_host_if.sv
// Host <-> CPU bundle: program load, run control, CPU fetch/retire, result stream.
// Modports: slave = host block, master = harness / driver side.
interface cpu_program_host_if #(
    parameter int PC_W = 6
);
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [7:0]      prog_data;
    logic            start;
    logic            abort;
    logic            cpu_rst_n;
    logic [7:0]      ins_byte;
    logic [PC_W-1:0] cpu_pc;
    logic            cpu_invalid;
    logic            cpu_send;
    logic [7:0]      cpu_acc;
    logic            res_valid;
    logic [7:0]      res_data;
    logic            res_ready;
    logic            busy;
    logic            done;
    logic [7:0]      retired_cnt;
    logic [7:0]      invalid_cnt;
    logic            overflow;

    modport slave (
        input  prog_we, prog_addr, prog_data, start, abort,
        input  cpu_pc, cpu_invalid, cpu_send, cpu_acc, res_ready,
        output cpu_rst_n, ins_byte, res_valid, res_data,
        output busy, done, retired_cnt, invalid_cnt, overflow
    );

    modport master (
        output prog_we, prog_addr, prog_data, start, abort,
        output cpu_pc, cpu_invalid, cpu_send, cpu_acc, res_ready,
        input  cpu_rst_n, ins_byte, res_valid, res_data,
        input  busy, done, retired_cnt, invalid_cnt, overflow
    );
endinterface

// File: rtl/cpu_program_host.sv
// Host side of the 8-bit CPU: program image, fetch byte server, retire monitor,
// result FIFO. Ports: clk, rst_n (async low), bus (cpu_program_host_if.slave).
module cpu_program_host #(
    parameter int PC_W   = 6,
    parameter int END_PC = 63,
    parameter int FIFO_D = 4
) (
    input logic              clk,
    input logic              rst_n,
    cpu_program_host_if.slave bus
);
    localparam int AW = $clog2(FIFO_D);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_D);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [7:0]    r_mem [2**PC_W];
    logic [7:0]    r_fifo [FIFO_D];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_ins;
    logic          r_crst_n;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    r_ret;
    logic [7:0]    r_inv;
    logic          r_ovf;

    logic w_run;
    logic w_launch;
    logic w_hold;
    logic w_retire;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_accept;
    logic w_end;

    assign w_run    = (r_state == S_RUN);
    // abort has priority over start
    assign w_launch = bus.start & ~w_run & ~bus.abort;
    assign w_hold   = ~bus.abort & ~w_launch;
    assign w_retire = w_run & bus.cpu_send;
    assign w_push   = w_retire & ~bus.cpu_invalid;
    assign w_pop    = (r_cnt != '0) & bus.res_ready;
    assign w_full   = (r_cnt == DEPTH);
    // a pop in the same cycle frees the slot a full FIFO needs
    assign w_accept = w_hold & w_push & (~w_full | w_pop);
    assign w_end    = w_retire & (bus.cpu_pc == PC_W'(END_PC));

    // Program image and FIFO storage carry no reset
    always_ff @(posedge clk) begin
        if (bus.prog_we && !w_run)
            r_mem[bus.prog_addr] <= bus.prog_data;
        if (w_accept)
            r_fifo[r_wp] <= bus.cpu_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ins    <= 8'h00;
            r_crst_n <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_ret    <= 8'h00;
            r_inv    <= 8'h00;
            r_ovf    <= 1'b0;
        end else begin
            r_ins <= w_run ? r_mem[bus.cpu_pc] : 8'h00;
            if (!w_hold) begin
                r_state  <= bus.abort ? S_IDLE : S_RUN;
                r_crst_n <= ~bus.abort;
                r_busy   <= ~bus.abort;
                r_done   <= 1'b0;
                r_wp     <= '0;
                r_rp     <= '0;
                r_cnt    <= '0;
                r_ret    <= 8'h00;
                r_inv    <= 8'h00;
                r_ovf    <= 1'b0;
            end else begin
                if (w_pop)
                    r_rp <= r_rp + AW'(1);
                if (w_accept)
                    r_wp <= r_wp + AW'(1);
                unique case ({w_accept, w_pop})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
                if (w_push && !w_accept)
                    r_ovf <= 1'b1;
                if (w_push && r_ret != 8'hFF)
                    r_ret <= r_ret + 8'd1;
                if (w_retire && bus.cpu_invalid && r_inv != 8'hFF)
                    r_inv <= r_inv + 8'd1;
                if (w_end) begin
                    r_state  <= S_DONE;
                    r_crst_n <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign bus.cpu_rst_n   = r_crst_n;
    assign bus.ins_byte    = r_ins;
    assign bus.res_valid   = (r_cnt != '0);
    assign bus.res_data    = (r_cnt != '0) ? r_fifo[r_rp] : 8'h00;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.retired_cnt = r_ret;
    assign bus.invalid_cnt = r_inv;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_cpu_program_host.sv
// Bench for cpu_program_host: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_cpu_program_host;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_program_host_if #(.PC_W(6)) bus ();

    cpu_program_host #(
        .PC_W(6), .END_PC(63), .FIFO_D(FD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model
    bit         m_run;
    bit         m_done;
    logic [7:0] m_mem [64];
    logic [7:0] m_ins;
    logic [7:0] m_q [$];
    int         m_ret;
    int         m_inv;
    bit         m_ovf;

    task automatic m_clear();
        m_q.delete();
        m_ret = 0;
        m_inv = 0;
        m_ovf = 0;
    endtask

    task automatic m_reset();
        m_run = 0;
        m_done = 0;
        m_ins = 8'h00;
        m_clear();
    endtask

    task automatic m_edge();
        logic [7:0] nins;
        bit pop;
        nins = m_run ? m_mem[bus.cpu_pc] : 8'h00;
        pop = (m_q.size() > 0) && bus.res_ready;
        if (!m_run && bus.prog_we)
            m_mem[bus.prog_addr] = bus.prog_data;
        if (bus.abort) begin
            m_run = 0;
            m_done = 0;
            m_clear();
        end else if (bus.start && !m_run) begin
            m_run = 1;
            m_done = 0;
            m_clear();
        end else begin
            if (pop)
                void'(m_q.pop_front());
            if (m_run && bus.cpu_send) begin
                if (!bus.cpu_invalid) begin
                    if (m_q.size() < FD)
                        m_q.push_back(bus.cpu_acc);
                    else
                        m_ovf = 1;
                    if (m_ret < 255) m_ret++;
                end else begin
                    if (m_inv < 255) m_inv++;
                end
                if (bus.cpu_pc == 6'd63) begin
                    m_run = 0;
                    m_done = 1;
                end
            end
        end
        m_ins = nins;
    endtask

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        logic [7:0] erd;
        erd = (m_q.size() > 0) ? m_q[0] : 8'h00;
        chk("cpu_rst_n", bus.cpu_rst_n, m_run);
        chk("busy", bus.busy, m_run);
        chk("done", bus.done, m_done);
        chk("ins_byte", bus.ins_byte, m_ins);
        chk("res_valid", bus.res_valid, m_q.size() > 0);
        chk("res_data", bus.res_data, erd);
        chk("retired_cnt", bus.retired_cnt, m_ret);
        chk("invalid_cnt", bus.invalid_cnt, m_inv);
        chk("overflow", bus.overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        chk_model();
    endtask

    task automatic idle_in();
        bus.prog_we = 0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.start = 0;
        bus.abort = 0;
        bus.cpu_pc = '0;
        bus.cpu_invalid = 0;
        bus.cpu_send = 0;
        bus.cpu_acc = '0;
        bus.res_ready = 0;
    endtask

    typedef struct {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        logic       start;
        logic       abort;
        logic [5:0] pc;
        logic       inv;
        logic       send;
        logic [7:0] acc;
        logic       ready;
        logic       e_busy;
        logic       e_done;
        logic       e_crst;
        logic       icare;
        logic [7:0] e_ins;
        logic       e_rv;
        logic [7:0] e_rd;
        logic [7:0] e_ret;
        logic [7:0] e_inv;
        logic       e_ovf;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(
        logic we, logic [5:0] ad, logic [7:0] dt,
        logic st, logic ab, logic [5:0] pc,
        logic iv, logic sd, logic [7:0] ac, logic rd,
        logic eb, logic ed, logic ec, logic ic,
        logic [7:0] ei, logic ev, logic [7:0] er,
        logic [7:0] et, logic [7:0] en, logic eo);
        vec_t v;
        v.we = we; v.addr = ad; v.data = dt;
        v.start = st; v.abort = ab; v.pc = pc;
        v.inv = iv; v.send = sd; v.acc = ac;
        v.ready = rd; v.e_busy = eb; v.e_done = ed;
        v.e_crst = ec; v.icare = ic; v.e_ins = ei;
        v.e_rv = ev; v.e_rd = er; v.e_ret = et;
        v.e_inv = en; v.e_ovf = eo;
        return v;
    endfunction

    logic [7:0] first_vals [4];

    initial begin
        idle_in();
        m_reset();
        for (int i = 0; i < 64; i++) m_mem[i] = 8'h00;
        #12;
        chk("rst cpu_rst_n", bus.cpu_rst_n, 1'b0);
        chk("rst ins_byte", bus.ins_byte, 8'h00);
        chk("rst res_valid", bus.res_valid, 1'b0);
        chk("rst res_data", bus.res_data, 8'h00);
        chk("rst busy", bus.busy, 1'b0);
        chk("rst done", bus.done, 1'b0);
        chk("rst retired", bus.retired_cnt, 8'h00);
        chk("rst invalid", bus.invalid_cnt, 8'h00);
        chk("rst overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;

        // give every program location a known value
        for (int i = 0; i < 64; i++) begin
            bus.prog_we = 1;
            bus.prog_addr = 6'(i);
            bus.prog_data = 8'($urandom);
            step();
        end
        idle_in();

        //        we ad dt   st ab pc iv sd acc  rd | bsy dn cr ic ins  rv rd   ret inv ov
        tbl.push_back(mk(1,0,8'h11,0,0,0,0,0,8'h00,0, 0,0,0,1,8'h00,0,8'h00,0,0,0));
        tbl.push_back(mk(1,1,8'h22,0,0,0,0,0,8'h00,0, 0,0,0,1,8'h00,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,1,0,0,0,0,8'h00,0, 1,0,1,1,8'h00,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,8'h00,0, 1,0,1,1,8'h11,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0,8'h00,0, 1,0,1,1,8'h22,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'h05,0, 1,0,1,1,8'h22,1,8'h05,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'h06,0, 1,0,1,1,8'h22,1,8'h05,2,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'h07,0, 1,0,1,1,8'h22,1,8'h05,3,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0,8'h00,1, 1,0,1,1,8'h22,1,8'h06,3,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0,8'h00,1, 1,0,1,1,8'h22,1,8'h07,3,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0,8'h00,1, 1,0,1,1,8'h22,0,8'h00,3,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,63,1,1,8'h99,0, 0,1,0,0,8'h00,0,8'h00,3,1,0));
        tbl.push_back(mk(0,0,8'h00,0,0,0,0,0,8'h00,0, 0,1,0,1,8'h00,0,8'h00,3,1,0));
        tbl.push_back(mk(0,0,8'h00,1,0,1,0,0,8'h00,0, 1,0,1,1,8'h00,0,8'h00,0,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'hA0,0, 1,0,1,1,8'h22,1,8'hA0,1,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'hA1,0, 1,0,1,1,8'h22,1,8'hA0,2,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'hA2,0, 1,0,1,1,8'h22,1,8'hA0,3,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'hA3,0, 1,0,1,1,8'h22,1,8'hA0,4,0,0));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,1,8'hA4,0, 1,0,1,1,8'h22,1,8'hA0,5,0,1));
        tbl.push_back(mk(0,0,8'h00,0,0,1,0,0,8'h00,1, 1,0,1,1,8'h22,1,8'hA1,5,0,1));
        tbl.push_back(mk(0,0,8'h00,0,1,1,0,0,8'h00,0, 0,0,0,1,8'h22,0,8'h00,0,0,0));

        foreach (tbl[i]) begin
            bus.prog_we = tbl[i].we;
            bus.prog_addr = tbl[i].addr;
            bus.prog_data = tbl[i].data;
            bus.start = tbl[i].start;
            bus.abort = tbl[i].abort;
            bus.cpu_pc = tbl[i].pc;
            bus.cpu_invalid = tbl[i].inv;
            bus.cpu_send = tbl[i].send;
            bus.cpu_acc = tbl[i].acc;
            bus.res_ready = tbl[i].ready;
            step();
            chk("tv busy", bus.busy, tbl[i].e_busy);
            chk("tv done", bus.done, tbl[i].e_done);
            chk("tv cpu_rst_n", bus.cpu_rst_n, tbl[i].e_crst);
            if (tbl[i].icare)
                chk("tv ins_byte", bus.ins_byte, tbl[i].e_ins);
            chk("tv res_valid", bus.res_valid, tbl[i].e_rv);
            chk("tv res_data", bus.res_data, tbl[i].e_rd);
            chk("tv retired", bus.retired_cnt, tbl[i].e_ret);
            chk("tv invalid", bus.invalid_cnt, tbl[i].e_inv);
            chk("tv overflow", bus.overflow, tbl[i].e_ovf);
        end
        idle_in();

        // write during RUN is ignored; abort keeps the program
        bus.start = 1; step(); idle_in();
        bus.prog_we = 1; bus.prog_addr = 0; bus.prog_data = 8'hEE;
        step(); idle_in();
        bus.abort = 1; step(); idle_in();
        chk("abort busy", bus.busy, 1'b0);
        chk("abort crst", bus.cpu_rst_n, 1'b0);
        bus.start = 1; step(); idle_in();
        bus.cpu_pc = 0; step();
        chk("mem0 kept", bus.ins_byte, 8'h11);

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < FD; i++) begin
            first_vals[i] = 8'($urandom);
            bus.cpu_pc = 6'd5;
            bus.cpu_send = 1;
            bus.cpu_acc = first_vals[i];
            step();
        end
        bus.cpu_acc = 8'hC4;
        bus.res_ready = 1;
        step();
        chk("full pp overflow", bus.overflow, 1'b0);
        chk("full pp head", bus.res_data, first_vals[1]);
        bus.cpu_send = 0;
        for (int i = 1; i < FD; i++) begin
            chk("full pp order", bus.res_data, first_vals[i]);
            step();
        end
        chk("full pp tail", bus.res_data, 8'hC4);
        step();
        chk("full pp empty", bus.res_valid, 1'b0);
        idle_in();

        // asynchronous reset mid-run
        bus.cpu_pc = 3; bus.cpu_send = 1; bus.cpu_acc = 8'h3C;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst busy", bus.busy, 1'b0);
        chk("arst crst", bus.cpu_rst_n, 1'b0);
        chk("arst res_valid", bus.res_valid, 1'b0);
        chk("arst retired", bus.retired_cnt, 8'h00);
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            bus.prog_we = ($urandom_range(0, 7) == 0);
            bus.prog_addr = 6'($urandom);
            bus.prog_data = 8'($urandom);
            bus.start = ($urandom_range(0, 24) == 0);
            bus.abort = ($urandom_range(0, 150) == 0);
            bus.cpu_pc = ($urandom_range(0, 30) == 0) ?
                         6'd63 : 6'($urandom);
            bus.cpu_invalid = ($urandom_range(0, 4) == 0);
            bus.cpu_send = $urandom_range(0, 1) == 1;
            bus.cpu_acc = 8'($urandom);
            bus.res_ready = ((c / 64) % 2 == 0) ?
                            ($urandom_range(0, 3) != 0) :
                            ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
